// File: rtl/rvc_align_queue.sv
// Halfword parcel queue between ifetch and decode. It realigns mixed 16/32-bit
// RV32C streams, including 32-bit instructions that straddle fetch words.
module rvc_align_queue #(
    parameter int DEPTH  = 8,
    parameter int RVC_EN = 1,
    parameter int PC_W   = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_word,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_is_c,
    output logic                       out_ill,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [15:0]     slots [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count_q;
    logic            synced;
    logic [PC_W-1:0] head_pc;

    logic [15:0]     hw0;
    logic [15:0]     hw1;
    logic            is_c_parcel;
    logic [CW-1:0]   need;
    logic [CW-1:0]   space;
    logic            enq;
    logic            deq;
    logic            enq_one;
    logic [CW-1:0]   enq_n;
    logic [CW-1:0]   deq_n;

    assign hw0         = slots[head];
    assign hw1         = slots[head + AW'(1)];
    assign is_c_parcel = (RVC_EN != 0) && (hw0[1:0] != 2'b11);
    assign need        = is_c_parcel ? CW'(1) : CW'(2);
    assign space       = DEPTH_C - count_q;

    assign in_ready  = (space >= CW'(2));
    assign out_valid = (count_q >= need);
    assign out_is_c  = out_valid && is_c_parcel;
    assign out_ill   = (RVC_EN == 0) && (hw0[1:0] != 2'b11) && out_valid;
    assign out_pc    = head_pc;
    assign count     = count_q;

    // Gated by out_valid so stale slot contents never leak to the decoder.
    always_comb begin
        out_inst = 32'h0;
        if (out_valid) begin
            out_inst = is_c_parcel ? {16'h0, hw0} : {hw1, hw0};
        end
    end

    // The first word after reset/flush may start mid-word (pc[1]=1).
    assign enq     = in_valid && in_ready && rdy_in && !flush;
    assign deq     = out_valid && out_ready && rdy_in && !flush;
    assign enq_one = !synced && in_pc[1];
    assign enq_n   = enq ? (enq_one ? CW'(1) : CW'(2)) : CW'(0);
    assign deq_n   = deq ? need : CW'(0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            synced  <= 1'b0;
            head_pc <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            synced  <= 1'b0;
        end else begin
            count_q <= count_q + enq_n - deq_n;
            if (enq) begin
                tail   <= tail + AW'(enq_n);
                synced <= 1'b1;
            end
            if (deq) begin
                head    <= head + AW'(need);
                head_pc <= head_pc + PC_W'({need, 1'b0});
            end else if (enq && !synced) begin
                head_pc <= in_pc;
            end
        end
    end

    // Slot storage carries no reset; occupancy is tracked by count/head/tail.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            if (enq_one) begin
                slots[tail] <= in_word[31:16];
            end else begin
                slots[tail]          <= in_word[15:0];
                slots[tail + AW'(1)] <= in_word[31:16];
            end
        end
    end

endmodule

// File: tb/tb_rvc_align_queue.sv
// Bench for rvc_align_queue: an RVC_EN=1 and an RVC_EN=0 instance share stimulus
// and are compared every cycle against a stream-position halfword model.
module tb_rvc_align_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_word;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready_c, out_valid_c, out_is_c_c, out_ill_c;
    logic [31:0] out_inst_c, out_pc_c;
    logic [3:0]  count_c;
    logic        in_ready_n, out_valid_n, out_is_c_n, out_ill_n;
    logic [31:0] out_inst_n, out_pc_n;
    logic [3:0]  count_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    rvc_align_queue #(.DEPTH(8), .RVC_EN(1), .PC_W(32)) dut_c (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_word(in_word), .in_pc(in_pc),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_inst(out_inst_c),
        .out_pc(out_pc_c), .out_is_c(out_is_c_c), .out_ill(out_ill_c), .count(count_c)
    );

    rvc_align_queue #(.DEPTH(8), .RVC_EN(0), .PC_W(32)) dut_n (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_word(in_word), .in_pc(in_pc),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_inst(out_inst_n),
        .out_pc(out_pc_n), .out_is_c(out_is_c_n), .out_ill(out_ill_n), .count(count_n)
    );

    // Model: halfwords indexed by absolute stream position; index 0 = RVC, 1 = no RVC.
    logic [15:0] mq [2][1024];
    int          mrd [2];
    int          mwr [2];
    logic [31:0] mpc [2];
    bit          msync [2];

    function automatic int mCount(int k);
        return mwr[k] - mrd[k];
    endfunction

    function automatic logic [15:0] mHw(int k, int off);
        return mq[k][(mrd[k] + off) & 1023];
    endfunction

    function automatic bit mIsC(int k);
        logic [15:0] h;
        h = mHw(k, 0);
        return (k == 0) && (h[1:0] != 2'b11);
    endfunction

    function automatic int mNeed(int k);
        return mIsC(k) ? 1 : 2;
    endfunction

    function automatic bit mValid(int k);
        return mCount(k) >= mNeed(k);
    endfunction

    function automatic bit mReady(int k);
        return (8 - mCount(k)) >= 2;
    endfunction

    function automatic logic [31:0] mInst(int k);
        if (!mValid(k)) return 32'h0;
        return mIsC(k) ? {16'h0, mHw(k, 0)} : {mHw(k, 1), mHw(k, 0)};
    endfunction

    function automatic bit mIll(int k);
        logic [15:0] h;
        h = mHw(k, 0);
        return (k == 1) && (h[1:0] != 2'b11) && mValid(k);
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n_in) begin
                mrd[k]   <= 0;
                mwr[k]   <= 0;
                mpc[k]   <= 32'h0;
                msync[k] <= 1'b0;
            end else if (flush) begin
                mrd[k]   <= mwr[k];
                msync[k] <= 1'b0;
            end else if (rdy_in) begin
                if (out_ready && mValid(k)) begin
                    mrd[k] <= mrd[k] + mNeed(k);
                    mpc[k] <= mpc[k] + 32'(2 * mNeed(k));
                end
                if (in_valid && mReady(k)) begin
                    msync[k] <= 1'b1;
                    if (!msync[k]) mpc[k] <= in_pc;
                    if (!msync[k] && in_pc[1]) begin
                        mq[k][mwr[k] & 1023] <= in_word[31:16];
                        mwr[k] <= mwr[k] + 1;
                    end else begin
                        mq[k][mwr[k] & 1023]       <= in_word[15:0];
                        mq[k][(mwr[k] + 1) & 1023] <= in_word[31:16];
                        mwr[k] <= mwr[k] + 2;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic compareModel();
        checkOutput("c_count",  32'(count_c),     32'(mCount(0)));
        checkOutput("c_ready",  32'(in_ready_c),  32'(mReady(0)));
        checkOutput("c_valid",  32'(out_valid_c), 32'(mValid(0)));
        checkOutput("c_inst",   out_inst_c,       mInst(0));
        checkOutput("c_pc",     out_pc_c,         mpc[0]);
        checkOutput("c_is_c",   32'(out_is_c_c),  32'(mIsC(0) && mValid(0)));
        checkOutput("c_ill",    32'(out_ill_c),   32'(mIll(0)));
        checkOutput("n_count",  32'(count_n),     32'(mCount(1)));
        checkOutput("n_ready",  32'(in_ready_n),  32'(mReady(1)));
        checkOutput("n_valid",  32'(out_valid_n), 32'(mValid(1)));
        checkOutput("n_inst",   out_inst_n,       mInst(1));
        checkOutput("n_pc",     out_pc_n,         mpc[1]);
        checkOutput("n_is_c",   32'(out_is_c_n),  32'(mIsC(1) && mValid(1)));
        checkOutput("n_ill",    32'(out_ill_n),   32'(mIll(1)));
    endtask

    task automatic tick();
        @(negedge clk_in);
        compareModel();
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] pc);
        in_valid = 1'b1;
        in_word  = word;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic popOne();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic redirect();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_word = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_ready", 32'(in_ready_c), 32'd1);
        checkOutput("rst_valid", 32'(out_valid_c), 32'd0);
        checkOutput("rst_count", 32'(count_c), 32'd0);
        checkOutput("rst_pc", out_pc_c, 32'h0);
        rst_n_in = 1'b1;
        tick();

        applyStimulus(32'h00A00093, 32'h0);
        checkOutput("t1_valid", 32'(out_valid_c), 32'd1);
        checkOutput("t1_inst", out_inst_c, 32'h00A00093);
        checkOutput("t1_is_c", 32'(out_is_c_c), 32'd0);
        popOne();
        checkOutput("t1_count", 32'(count_c), 32'd0);
        checkOutput("t1_empty", 32'(out_valid_c), 32'd0);

        redirect();
        applyStimulus(32'h00014501, 32'h100);
        checkOutput("t2_inst0", out_inst_c, 32'h00004501);
        checkOutput("t2_pc0", out_pc_c, 32'h100);
        checkOutput("t2_is_c0", 32'(out_is_c_c), 32'd1);
        popOne();
        checkOutput("t2_inst1", out_inst_c, 32'h00000001);
        checkOutput("t2_pc1", out_pc_c, 32'h102);
        popOne();

        redirect();
        applyStimulus(32'h00934505, 32'h200);
        checkOutput("t3_inst0", out_inst_c, 32'h00004505);
        popOne();
        checkOutput("t3_partial_valid", 32'(out_valid_c), 32'd0);
        checkOutput("t3_partial_count", 32'(count_c), 32'd1);
        applyStimulus(32'h00000000, 32'h204);
        checkOutput("t3_inst1", out_inst_c, 32'h00000093);
        checkOutput("t3_pc1", out_pc_c, 32'h202);
        checkOutput("t3_is_c1", 32'(out_is_c_c), 32'd0);

        redirect();
        applyStimulus(32'h45010000, 32'h302);
        checkOutput("t4_count", 32'(count_c), 32'd1);
        checkOutput("t4_inst", out_inst_c, 32'h00004501);
        checkOutput("t4_pc", out_pc_c, 32'h302);
        checkOutput("t4_is_c", 32'(out_is_c_c), 32'd1);

        // Fill with an odd offset so the last 32-bit parcel straddles slot 7 / slot 0.
        redirect();
        applyStimulus(32'h45010000, 32'h502);
        for (int i = 0; i < 3; i++) applyStimulus(32'h00A00093 + (32'(i) << 16), 32'h0);
        checkOutput("t5_full7_ready", 32'(in_ready_c), 32'd0);
        checkOutput("t5_full7_count", 32'(count_c), 32'd7);
        popOne();
        checkOutput("t5_space_ready", 32'(in_ready_c), 32'd1);
        applyStimulus(32'h00A00093 + (32'd3 << 16), 32'h0);
        checkOutput("t5_full8_ready", 32'(in_ready_c), 32'd0);
        checkOutput("t5_full8_count", 32'(count_c), 32'd8);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t5_drain_inst", out_inst_c, 32'h00A00093 + (32'(i) << 16));
            checkOutput("t5_drain_pc", out_pc_c, 32'h504 + 32'(4 * i));
            popOne();
        end
        checkOutput("t5_drain_count", 32'(count_c), 32'd0);

        redirect();
        applyStimulus(32'h45010000, 32'h602);
        applyStimulus(32'h00A00093, 32'h0);
        applyStimulus(32'h00B00093, 32'h0);
        checkOutput("t6_pre_count", 32'(count_c), 32'd5);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_word = 32'h00C00093;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("t6_flush_count", 32'(count_c), 32'd0);
        checkOutput("t6_flush_valid", 32'(out_valid_c), 32'd0);
        applyStimulus(32'h00A00093, 32'h400);
        checkOutput("t6_reseed_pc", out_pc_c, 32'h400);

        redirect();
        applyStimulus(32'h00004501, 32'h700);
        checkOutput("t7_ill", 32'(out_ill_n), 32'd1);
        checkOutput("t7_is_c", 32'(out_is_c_n), 32'd0);
        checkOutput("t7_inst", out_inst_n, 32'h00004501);
        checkOutput("t7_rvc_ill", 32'(out_ill_c), 32'd0);
        popOne();

        redirect();
        applyStimulus(32'h00D00093, 32'h800);
        rdy_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_word = 32'h00E00093;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t8_hold_count", 32'(count_c), 32'd2);
            checkOutput("t8_hold_inst", out_inst_c, 32'h00D00093);
        end
        rdy_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;

        applyStimulus(32'h00F00093, 32'h0);
        in_valid = 1'b1;
        #1 rst_n_in = 1'b0;
        #1;
        checkOutput("t9_async_count", 32'(count_c), 32'd0);
        checkOutput("t9_async_valid", 32'(out_valid_c), 32'd0);
        checkOutput("t9_async_pc", out_pc_c, 32'h0);
        tick();
        in_valid = 1'b0;
        rst_n_in = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvc_align_queue.md
Name: rvc_align_queue

Overview:
- Parametrised instruction-parcel queue between ifetch and the decoder. ifetch pushes 32-bit fetch words; the decoder pops one aligned instruction per handshake.
- Buffers 16-bit halfwords and handles RV32C mixed 16/32-bit streams: 32-bit instructions straddling fetch words, and entry at PC with pc[1]=1.
- Generalises the single-word, combinational decode path to a configurable depth, with an optional C-extension mode.

Parameters:
DEPTH, 8, halfword slots; power of two, >= 4
RVC_EN, 1, 1 = RV32C parcels recognised; 0 = every instruction 32-bit
PC_W, 32, program-counter width

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global pause when low
flush  input  1  discard all buffered parcels (branch mispredict / redirect)
in_valid  input  1  fetch word present
in_ready  output  1  queue can accept a fetch word
in_word  input  32  fetch word; bits[15:0] = lower halfword
in_pc  input  PC_W  address of in_word's first valid halfword
out_valid  output  1  aligned instruction available
out_ready  input  1  decoder accepts instruction
out_inst  output  32  instruction; compressed = {16'b0, hw}
out_pc  output  PC_W  address of out_inst
out_is_c  output  1  out_inst is 16-bit
out_ill  output  1  compressed parcel seen while RVC_EN=0
count  output  $clog2(DEPTH)+1  halfwords held

Behaviour:
- Reset (rst_n_in low, async): head=tail=0, count=0, synced=0, head_pc=0. All outputs 0 except in_ready=1.
- Storage: circular halfword array. head/tail pointers wrap modulo DEPTH. head_pc register = address of slot[head].
- Enqueue fires on in_valid && in_ready && rdy_in && !flush.
  - synced=0: head_pc <= in_pc and synced <= 1. If in_pc[1]=1, only in_word[31:16] is written (1 halfword); otherwise both halfwords.
  - synced=1: in_pc is ignored and both halfwords are written. ifetch guarantees contiguity.
- in_ready = (DEPTH - count >= 2). It is computed from registered count only; there is no same-cycle dequeue bypass.
- Parcel sizing:
  - need = 1 when RVC_EN=1 and slot[head][1:0] != 2'b11; otherwise need = 2.
  - out_valid = (count >= need).
  - need=1: out_inst = {16'b0, slot[head]}, out_is_c=1.
  - need=2: out_inst = {slot[head+1], slot[head]}, out_is_c=0.
  - out_pc = head_pc.
  - out_ill = (RVC_EN=0 && slot[head][1:0] != 2'b11 && out_valid).
- Outputs are combinational from registered state only; there is no input-to-output path in the same cycle. An enqueued word is visible at the earliest on the next cycle.
- Dequeue fires on out_valid && out_ready && rdy_in && !flush:
  - head += need (mod DEPTH)
  - head_pc += 2*need (PC_W-bit wrap)
  - count -= need
- Simultaneous enqueue and dequeue: count <= count + enq_n - need. Both pointers update in the same cycle.
- flush (synchronous, highest priority, independent of rdy_in): head=tail=0, count=0, synced=0. A same-cycle in_valid or out_ready is ignored. The next accepted word re-seeds head_pc.
- rdy_in low: no state change and no handshake completes. Outputs hold their values.
- A 32-bit instruction with only its low half buffered keeps out_valid=0 until the next word arrives. No partial output is produced.
- Full: count reaching DEPTH-1 or DEPTH deasserts in_ready. out_valid still operates.
- Pointer wrap: a 32-bit parcel whose halves occupy slot[DEPTH-1] and slot[0] is emitted correctly.
- Async reset asserted mid-operation clears all state immediately. No handshake completes in that cycle.

Test Plan:
- Reset, push in_word=0x00A00093 at in_pc=0x0 -> next cycle out_valid=1, out_inst=0x00A00093, out_pc=0x0, out_is_c=0. Pop -> count=0, out_valid=0.
- Push 0x00014501 (c.li a0,0 then c.nop) at pc 0x100 -> two pops in sequence:
  - first: out_inst=0x00004501, out_pc=0x100, out_is_c=1
  - second: out_inst=0x00000001, out_pc=0x102
- Straddle case, pc 0x200: word0=0x00934505, word1=0x00000000.
  - Before word1: c.li emitted; out_valid=0 with count=1 (low half 0x0093 of the 32-bit instruction only).
  - After word1: out_inst=0x00000093, out_pc=0x202.
- Push 0x45010000 at in_pc=0x302 (pc[1]=1) -> count=1; out_inst=0x00004501, out_pc=0x302, out_is_c=1.
- DEPTH=8, push with out_ready=0 -> in_ready drops at count=8. Drain across wrap with 32-bit parcels -> out_inst order and PCs are exact; no loss.
- flush asserted together with in_valid and out_ready at count=5 -> count=0, no dequeue. The next push at 0x400 sets out_pc=0x400.
- RVC_EN=0, push 0x00004501 -> out_ill=1, out_is_c=0, need=2.
- rdy_in=0 for 3 cycles with all handshakes high -> count and outputs unchanged.
